// File: rtl/fir_stream_pkg.sv
// Shared widths and sample/block types for the FIR output stream.
package fir_stream_pkg;

    localparam int FIR_OUT_W = 40;
    localparam int FIR_LANES = 2;

    typedef logic signed [FIR_OUT_W-1:0] sample_t;
    typedef sample_t block_t [FIR_LANES-1:0];

endpackage

// File: rtl/fir_block_fifo.sv
// Block-wide FIFO with show-ahead read; each lane lives in its own memory array.
module fir_block_fifo
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = FIR_OUT_W,
    parameter int LANES  = FIR_LANES,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop_block,
    input  logic signed [DATA_W-1:0]   wr_data [LANES-1:0],
    output logic signed [DATA_W-1:0]   rd_data [LANES-1:0],
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop_block && !empty;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_W-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (push_ok) mem[wr_ptr_reg] <= wr_data[gi];
            end

            assign rd_data[gi] = mem[rd_ptr_reg];
        end
    endgenerate

endmodule

// File: rtl/fir_p2s_serializer.sv
// Turns LANES-wide FIR output blocks into a one-sample-per-clock valid/ready stream.
module fir_p2s_serializer
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = FIR_OUT_W,
    parameter int LANES  = FIR_LANES,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data [LANES-1:0],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES-1);

    logic signed [DATA_W-1:0] head_block [LANES-1:0];
    logic [LW-1:0]            lane_idx_reg;
    logic [LW-1:0]            lane_idx_next;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop_lane;
    logic                     lane_last;
    logic                     pop_block;

    fir_block_fifo #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (push),
        .pop_block (pop_block),
        .wr_data   (in_data),
        .rd_data   (head_block),
        .count     (fill),
        .full      (full),
        .empty     (empty)
    );

    // Full means not ready, even if the head block finishes draining this cycle.
    assign in_ready  = !rst && !full;
    assign push      = in_valid && in_ready;

    assign out_valid = !empty;
    assign out_data  = head_block[lane_idx_reg];
    assign lane_last = (lane_idx_reg == LAST_LANE);
    assign out_last  = out_valid && lane_last;
    assign pop_lane  = out_valid && out_ready;
    assign pop_block = pop_lane && lane_last;

    always_comb begin
        lane_idx_next = lane_idx_reg;
        if (pop_lane) begin
            lane_idx_next = lane_last ? '0 : lane_idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx_reg <= '0;
        end else begin
            lane_idx_reg <= lane_idx_next;
        end
    end

endmodule

// File: tb/tb_fir_p2s_serializer.sv
// Directed stimulus with a scoreboard queue; a monitor checks every accepted output sample.
module tb_fir_p2s_serializer;
    import fir_stream_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [39:0] in_data [1:0];
    logic               out_valid;
    logic               out_ready;
    logic signed [39:0] out_data;
    logic               out_last;
    logic [2:0]         fill;

    int tests = 0;
    int fails = 0;
    logic [40:0] exp_q [$];

    fir_p2s_serializer #(.DATA_W(40), .LANES(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected {last, data} entry.
    initial begin
        logic [40:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample: got last=%0b data=%h expected none", out_last, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        fails++;
                        $display("FAIL sample: got last=%0b data=%h expected last=%0b data=%h",
                                 out_last, out_data, e[40], e[39:0]);
                    end else begin
                        $display("[TB] sample data=%h last=%0b", out_data, out_last);
                    end
                end
            end
        end
    end

    task automatic push_blk(input logic [39:0] a, input logic [39:0] b);
        bit ok = 0;
        in_data[0] = a;
        in_data[1] = b;
        in_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({1'b0, a});
                exp_q.push_back({1'b1, b});
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 40 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("[TB] push lane0=%h lane1=%h", a, b);
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        check(name, {63'd0, done}, 64'd1);
        check({name, "_fill"}, {61'd0, fill}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_last", {63'd0, out_last}, 64'd0);
        check("reset_fill", {61'd0, fill}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        step();

        // Single block
        out_ready = 1'b1;
        push_blk(40'sd5, -40'sd3);
        @(negedge clk);
        check("single_valid", {63'd0, out_valid}, 64'd1);
        check("single_lane0", {24'd0, out_data}, {24'd0, 40'd5});
        check("single_last0", {63'd0, out_last}, 64'd0);
        check("single_fill", {61'd0, fill}, 64'd1);
        wait_drain("single_drain");
        step();

        // Burst fill with out_ready low
        out_ready = 1'b0;
        for (int n = 1; n <= 4; n++) push_blk(40'(2*n), 40'(2*n+1));
        in_data[0] = 40'd10;
        in_data[1] = 40'd11;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("burst_in_ready", {63'd0, in_ready}, 64'd0);
            check("burst_fill", {61'd0, fill}, 64'd4);
        end
        step();
        out_ready = 1'b1;
        push_blk(40'd10, 40'd11);
        push_blk(40'd12, 40'd13);
        wait_drain("burst_drain");
        step();

        // Push coinciding with final-lane pop
        out_ready = 1'b0;
        push_blk(40'd100, 40'd101);
        push_blk(40'd102, 40'd103);
        out_ready = 1'b1;
        step();
        in_data[0] = 40'd104;
        in_data[1] = 40'd105;
        in_valid   = 1'b1;
        @(negedge clk);
        check("simul_fill_before", {61'd0, fill}, 64'd2);
        check("simul_head_last", {63'd0, out_last}, 64'd1);
        check("simul_in_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            exp_q.push_back({1'b0, 40'd104});
            exp_q.push_back({1'b1, 40'd105});
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("simul_fill_after", {61'd0, fill}, 64'd2);
        check("simul_head", {24'd0, out_data}, {24'd0, 40'd102});
        step();
        out_ready = 1'b1;
        wait_drain("simul_drain");
        step();

        // Backpressure mid-block with extreme values
        out_ready = 1'b0;
        push_blk(40'h7F_FFFF_FFFF, 40'h80_0000_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_data", {24'd0, out_data}, {24'd0, 40'h80_0000_0000});
            check("bp_hold_last", {63'd0, out_last}, 64'd1);
            step();
        end
        out_ready = 1'b1;
        wait_drain("bp_drain");
        step();

        // Steady rate: one block every second cycle
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid   = (c % 2 == 0);
            in_data[0] = 40'(1000 + c);
            in_data[1] = 40'(2000 + c);
            @(negedge clk);
            if (c > 0) check("steady_valid", {63'd0, out_valid}, 64'd1);
            check("steady_fill", {63'd0, (fill <= 3'd1)}, 64'd1);
            check("steady_in_ready", {63'd0, in_ready}, 64'd1);
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, 40'(1000 + c)});
                exp_q.push_back({1'b1, 40'(2000 + c)});
            end
            step();
        end
        in_valid = 1'b0;
        wait_drain("steady_drain");
        step();

        // Reset mid-operation
        out_ready = 1'b0;
        push_blk(40'd200, 40'd201);
        push_blk(40'd202, 40'd203);
        push_blk(40'd204, 40'd205);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("midrst_fill", {61'd0, fill}, 64'd3);
        check("midrst_head_last", {63'd0, out_last}, 64'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_fill0", {61'd0, fill}, 64'd0);
        check("midrst_in_ready1", {63'd0, in_ready}, 64'd1);
        step();
        out_ready = 1'b1;
        push_blk(40'd300, 40'd301);
        wait_drain("midrst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
